// File: rtl/b08_job_feeder.sv
// Job sequencer for the b08 ROM matcher: queues job words, launches each one, and returns the tagged result.
// Latency: a popped job raises RES_VALID 2+RUN_CYCLES+1 cycles after LAUNCH0; back-to-back jobs start every 2+RUN_CYCLES+2 cycles.
// Backpressure: an unaccepted result blocks the next launch. The queue then fills, and IN_READY drops at FIFO_DEPTH entries.
//
// Ports:
//   CLOCK, RESET                 shared clock, synchronous active-high reset
//   IN_VALID/IN_READY/IN_DATA    job word input (valid/ready)
//   START, I, O_IN               matcher control, job word and result
//   RES_VALID/RES_READY          result output (valid/ready), RES_DATA = matcher O, RES_TAG = job word
//   BUSY                         high whenever the sequencer is not idle
module b08_job_feeder #(
    parameter int FIFO_DEPTH    = 4,
    parameter int RUN_CYCLES    = 16,
    parameter int RESYNC_CYCLES = 18
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       IN_VALID,
    input  logic [7:0] IN_DATA,
    output logic       IN_READY,
    output logic       START,
    output logic [7:0] I,
    input  logic [3:0] O_IN,
    output logic       RES_VALID,
    input  logic       RES_READY,
    output logic [3:0] RES_DATA,
    output logic [7:0] RES_TAG,
    output logic       BUSY
);

    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(RESYNC_CYCLES + 1);

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = CNTW'(1);
    localparam logic [AW:0]   DEPTH_C   = CNTW'(FIFO_DEPTH);
    localparam logic [CW-1:0] RUN_LD    = CW'(RUN_CYCLES);
    localparam logic [CW-1:0] RESYNC_LD = CW'(RESYNC_CYCLES);
    localparam logic [CW-1:0] TMR_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_RESYNC  = 3'd0,
        S_IDLE    = 3'd1,
        S_LAUNCH0 = 3'd2,
        S_LAUNCH1 = 3'd3,
        S_RUN     = 3'd4,
        S_COLLECT = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tmr_q, tmr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [7:0]    job_q, job_d;
    logic          res_valid_q, res_valid_d;
    logic [3:0]    res_data_q, res_data_d;
    logic [7:0]    res_tag_q, res_tag_d;

    logic in_ready;
    logic push;
    logic pop;
    logic slot_free;

    // ---------------- state register ----------------
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= S_RESYNC;
            tmr_q       <= RESYNC_LD;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            job_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            job_q       <= job_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_tag_q   <= res_tag_d;
        end
    end

    // Queue storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge CLOCK) begin
        mem_q <= mem_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        job_d       = job_q;
        pop         = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_tag_d   = res_tag_q;

        // The slot counts as free if the current result is being taken this cycle.
        slot_free = !res_valid_q || RES_READY;
        if (res_valid_q && RES_READY) begin
            res_valid_d = 1'b0;
        end

        case (state_q)
            S_RESYNC: begin
                // The matcher has no reset. Holding START low longer than one full run
                // returns it to its start state from anywhere.
                if (tmr_q <= TMR_ONE) begin
                    tmr_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            S_IDLE: begin
                if ((count_q != '0) && slot_free) begin
                    pop     = 1'b1;
                    job_d   = mem_q[rd_ptr_q];
                    state_d = S_LAUNCH0;
                end
            end
            S_LAUNCH0: begin
                state_d = S_LAUNCH1;
            end
            S_LAUNCH1: begin
                tmr_d   = RUN_LD;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (tmr_q <= TMR_ONE) begin
                    tmr_d   = '0;
                    state_d = S_COLLECT;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            S_COLLECT: begin
                // The launch condition guaranteed the slot is empty, so no overwrite can occur.
                res_valid_d = 1'b1;
                res_data_d  = O_IN;
                res_tag_d   = job_q;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_RESYNC;
                tmr_d   = RESYNC_LD;
            end
        endcase
    end

    // Job queue. Readiness uses the registered count only, so a full queue refuses a push
    // even in the cycle it pops.
    always_comb begin
        in_ready = (count_q != DEPTH_C);
        push     = IN_VALID && in_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = IN_DATA;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        START     = (state_q == S_LAUNCH0) || (state_q == S_LAUNCH1);
        BUSY      = (state_q != S_IDLE);
        I         = job_q;  // held through RUN so the matcher never sees a glitch
        IN_READY  = in_ready;
        RES_VALID = res_valid_q;
        RES_DATA  = res_data_q;
        RES_TAG   = res_tag_q;
    end

endmodule

// File: doc/b08_job_feeder.md
Name: b08_job_feeder

Overview:
- Upstream sequencer for the b08 ROM matcher: queues 8-bit job words, issues each one to the matcher via its START/I protocol, and waits out the fixed matcher run.
- Captures the matcher's 4-bit O result and presents it, tagged with the job word, on a valid/ready result port.
- Shares the matcher clock; the matcher has no reset, so this block also owns resynchronisation after reset.

Parameters:
- FIFO_DEPTH, 4, job queue entries (power of 2, ≥2)
- RUN_CYCLES, 16, cycles START is held low between launch and result capture
- RESYNC_CYCLES, 18, post-reset holdoff with START low; must be ≥ RUN_CYCLES+1

Ports:
- CLOCK  in  1  rising-edge clock, shared with the matcher
- RESET  in  1  synchronous, active-high reset
- IN_VALID  in  1  job word offered
- IN_DATA  in  8  job word
- IN_READY  out  1  queue can accept; equals (count != FIFO_DEPTH)
- START  out  1  to matcher START
- I  out  8  to matcher I
- O_IN  in  4  from matcher O
- RES_VALID  out  1  result held
- RES_READY  in  1  result consumer accepts
- RES_DATA  out  4  captured O_IN
- RES_TAG  out  8  job word that produced RES_DATA
- BUSY  out  1  high in any state except IDLE

Behaviour:
- Reset values: START=0, I=0, RES_VALID=0, RES_DATA=0, RES_TAG=0, queue empty, IN_READY=1, BUSY=1, state=RESYNC, holdoff counter=RESYNC_CYCLES.
- Queue: push when IN_VALID && IN_READY; pop on launch. IN_READY depends on the registered count only, so a full queue refuses a push even if it pops in the same cycle. Order is FIFO, with wrap-around pointers.
- FSM states: RESYNC, IDLE, LAUNCH0, LAUNCH1, RUN, COLLECT.
- RESYNC: START=0; decrement the counter each cycle; go to IDLE when it reaches 0. This guarantees the matcher has returned to its start state from any state.
- IDLE: launch when the queue is non-empty and the result slot is free (RES_VALID=0, or RES_VALID && RES_READY this cycle). On launch, pop the head into a job register and go to LAUNCH0.
- LAUNCH0: START=1, I=job. Next state is LAUNCH1.
- LAUNCH1: START=1, I=job held; the matcher samples I at the end of this cycle. Load the counter with RUN_CYCLES and go to RUN.
- RUN: START=0, I holds job. Decrement each cycle; go to COLLECT at 0.
- COLLECT: O_IN is valid. Register RES_DATA=O_IN, RES_TAG=job, RES_VALID=1, then go to IDLE. The result slot is always free here, because launch required it.
- Launch-to-RES_VALID latency is 2+RUN_CYCLES+1 = 19 cycles. The earliest next LAUNCH0 is the cycle after COLLECT, giving a back-to-back job period of 20 cycles.
- Result handshake: RES_VALID drops on the edge where RES_VALID && RES_READY. RES_DATA and RES_TAG are stable while RES_VALID=1 and not accepted.
- Backpressure: while a result is unaccepted, no launch occurs and the queue may fill.
- Reset mid-job: the queue and result are discarded, and the block enters RESYNC. No START pulse is issued until the holdoff completes.
- I is a don't-care outside LAUNCH0 through RUN, but is driven with job (no glitching to 0 during RUN).

Test Plan:
- After reset, push 0x8A at cycle 0 → START=1 only during the 2 launch cycles, which follow the 18-cycle holdoff. RES_VALID rises 19 cycles after LAUNCH0 with RES_DATA=0xB, RES_TAG=0x8A.
- Push 0x00, 0xFF, 0x8A back-to-back with RES_READY=1 → results in order: 0xF/0x00, 0xE/0xFF, 0xB/0x8A. Consecutive LAUNCH0 cycles are 20 cycles apart.
- Push 5 words with FIFO_DEPTH=4 while the first job is running → IN_READY=0 once 4 words are queued; no words are lost or duplicated; tags come out in push order.
- Hold RES_READY=0 after the first result → RES_VALID/RES_DATA/RES_TAG are stable, START stays 0, and the next launch occurs the cycle after RES_READY=1 is accepted.
- Assert RESET during RUN → START=0 for 18 cycles and the queue reads empty. A new push of 0x00 then yields RES_DATA=0xF (the matcher has resynchronised).
- Push and pop in the same cycle at counts 0, 2 and full → the count and IN_READY follow the registered-count rule above.
